perf_counter_unit: RTL

- Synthesizable hardware performance monitor for the pipelined LEG core.
- Sits beside the hazard unit and controller and consumes their stall, flush and branch strobes, plus InstrE, the I/D cache stall lines and the PC.
- Accumulates run statistics in on-chip counters and freezes them when a stop PC is reached.
- Results are read back through a registered select/read port, so profiling works on silicon and not only in simulation.

---
 rtl/perf_pkg.sv | 34 +++
 rtl/perf_sat_counter.sv | 24 ++
 rtl/perf_counter_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter unit: counter indices and
// the run-control state encoding.
package perf_pkg;

    localparam int NUM_CNT = 16;
    // Counters 0..13 are plain event counters; 14 is the max tracker, 15 reserved.
    localparam int NUM_EV  = 14;

    typedef enum logic [3:0] {
        CNT_CYCLES      = 4'd0,
        CNT_INSTR       = 4'd1,
        CNT_UOP         = 4'd2,
        CNT_WASTED      = 4'd3,
        CNT_BRANCH      = 4'd4,
        CNT_TAKEN       = 4'd5,
        CNT_ISTALL_MISS = 4'd6,
        CNT_DSTALL_MISS = 4'd7,
        CNT_DSTALL_CYC  = 4'd8,
        CNT_LDR         = 4'd9,
        CNT_PCSRC       = 4'd10,
        CNT_PCWR        = 4'd11,
        CNT_FLUSHD      = 4'd12,
        CNT_FLUSHE      = 4'd13,
        CNT_MAX_DSTALL  = 4'd14,
        CNT_RSVD        = 4'd15
    } cnt_idx_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perf_state_e;

endpackage

// File: rtl/perf_sat_counter.sv
// Unsigned up-counter with synchronous clear that sticks at all-ones
// instead of wrapping.
module perf_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Performance monitor for the pipelined LEG core: counts pipeline events
// between start and the stop PC, with a registered select/read port.
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int          CNT_W   = 32,
    parameter logic [31:0] STOP_PC = 32'hb6eac824
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic [31:0]      PCF,
    input  logic [31:0]      InstrE,
    input  logic             StallE,
    input  logic             StallD,
    input  logic             StalluOp,
    input  logic             FlushD,
    input  logic             FlushE,
    input  logic             ldrStallD,
    input  logic             PCSrcW,
    input  logic             PCWrPendingF,
    input  logic             BranchE,
    input  logic             BranchTakenE,
    input  logic             IStall,
    input  logic             DStall,
    input  logic             rd_en,
    input  logic [3:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             running,
    output logic             done,
    output logic [1:0]       dbg_state
);

    perf_state_e      state_q;
    logic             running_q;
    logic             done_q;
    logic [31:0]      prev_instr_q;
    logic             prev_istall_q;
    logic             prev_dstall_q;
    logic             prev_ldr_q;
    logic             prev_pcsrc_q;
    logic             prev_pcwr_q;
    logic [CNT_W-1:0] dstall_run_q;
    logic [CNT_W-1:0] max_dstall_q;
    logic [CNT_W-1:0] rd_data_q;
    logic             rd_valid_q;

    logic              in_run;
    logic              cnt_clr;
    logic              instr_ev;
    logic [NUM_EV-1:0] ev;
    logic [CNT_W-1:0]  run_inc;
    logic [CNT_W-1:0]  cnt [NUM_CNT];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (PCF == STOP_PC) begin
                        state_q   <= DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    // History for edge detection runs in every state, so a level already
    // high at start is not mistaken for a fresh event.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_instr_q  <= '0;
            prev_istall_q <= 1'b0;
            prev_dstall_q <= 1'b0;
            prev_ldr_q    <= 1'b0;
            prev_pcsrc_q  <= 1'b0;
            prev_pcwr_q   <= 1'b0;
        end else begin
            prev_instr_q  <= InstrE;
            prev_istall_q <= IStall;
            prev_dstall_q <= DStall;
            prev_ldr_q    <= ldrStallD;
            prev_pcsrc_q  <= PCSrcW;
            prev_pcwr_q   <= PCWrPendingF;
        end
    end

    assign in_run  = (state_q == RUN);
    assign cnt_clr = reset || clear;

    always_comb begin
        instr_ev             = (InstrE != prev_instr_q) && (InstrE != 32'd0);
        ev                   = '0;
        ev[CNT_CYCLES]       = 1'b1;
        ev[CNT_INSTR]        = instr_ev;
        ev[CNT_UOP]          = StallD && !StalluOp;
        ev[CNT_WASTED]       = (InstrE == 32'd0) || StallE;
        ev[CNT_BRANCH]       = instr_ev && BranchE;
        ev[CNT_TAKEN]        = instr_ev && BranchTakenE;
        ev[CNT_ISTALL_MISS]  = IStall && !prev_istall_q;
        ev[CNT_DSTALL_MISS]  = DStall && !prev_dstall_q;
        ev[CNT_DSTALL_CYC]   = DStall;
        ev[CNT_LDR]          = ldrStallD && !prev_ldr_q;
        ev[CNT_PCSRC]        = PCSrcW && !prev_pcsrc_q;
        ev[CNT_PCWR]         = PCWrPendingF && !prev_pcwr_q;
        ev[CNT_FLUSHD]       = FlushD;
        ev[CNT_FLUSHE]       = FlushE;
    end

    for (genvar i = 0; i < NUM_EV; i++) begin : g_cnt
        perf_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk_i (clk),
            .clr_i (cnt_clr),
            .inc_i (in_run && ev[i]),
            .cnt_o (cnt[i])
        );
    end

    // Length of the current DStall burst including this cycle, saturated.
    assign run_inc = (dstall_run_q == '1) ? dstall_run_q : dstall_run_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            dstall_run_q <= '0;
        end else begin
            dstall_run_q <= (in_run && DStall) ? run_inc : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (cnt_clr) begin
            max_dstall_q <= '0;
        end else if (in_run && DStall && (run_inc > max_dstall_q)) begin
            max_dstall_q <= run_inc;
        end
    end

    assign cnt[CNT_MAX_DSTALL] = max_dstall_q;
    assign cnt[CNT_RSVD]       = '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= cnt[rd_sel];
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign running   = running_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule
